// File: rtl/wb_src.sv
// ============================================================================
// Module   : wb_src
// Function : Writeback source sequencer; selects ALU or load data and issues
//            register-file writes, splitting wide results into two writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_src #(
  parameter int unsigned REGISTER_DATA_BIT_WIDTH = 16,
  parameter int unsigned REG_ADDR_WIDTH          = 4,
  parameter int unsigned HI_REG_ADDR             = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] alu_result,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] alu_result_hi,
  input  logic [REGISTER_DATA_BIT_WIDTH-1:0] mem_data,
  input  logic                               Mem_To_Reg,
  input  logic                               Wide,
  input  logic [REG_ADDR_WIDTH-1:0]          dest_addr,
  output logic                               reg_write,
  output logic [REG_ADDR_WIDTH-1:0]          write_addr,
  output logic [REGISTER_DATA_BIT_WIDTH-1:0] write_data,
  output logic                               busy
);

  localparam logic [REG_ADDR_WIDTH-1:0] c_hi_addr = REG_ADDR_WIDTH'(HI_REG_ADDR);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE_LO = 2'd1,
    WRITE_HI = 2'd2
  } state_t;

  state_t                             r_state;
  state_t                             w_next_state;
  logic                               r_wide;
  logic [REGISTER_DATA_BIT_WIDTH-1:0] r_hi_data;
  logic [REG_ADDR_WIDTH-1:0]          r_wr_addr;
  logic [REGISTER_DATA_BIT_WIDTH-1:0] r_wr_data;
  logic                               w_accept;
  logic                               w_hi_pending;

  assign w_hi_pending = (r_state == WRITE_LO) && r_wide;
  assign w_accept     = in_valid && in_ready;
  assign write_addr   = r_wr_addr;
  assign write_data   = r_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = ~w_hi_pending;
    busy         = w_hi_pending;
    reg_write    = (r_state != IDLE);
    case (r_state)
      IDLE:     w_next_state = w_accept ? WRITE_LO : IDLE;
      WRITE_LO: begin
        if (r_wide)        w_next_state = WRITE_HI;
        else if (w_accept) w_next_state = WRITE_LO;
        else               w_next_state = IDLE;
      end
      WRITE_HI: w_next_state = w_accept ? WRITE_LO : IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Write address/data are registered so they hold their last value while idle;
  // an accept can never coincide with the upper-half step since in_ready is low then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wide    <= 1'b0;
      r_hi_data <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_accept) begin
      r_wide    <= Wide & ~Mem_To_Reg;
      r_hi_data <= alu_result_hi;
      r_wr_addr <= dest_addr;
      r_wr_data <= Mem_To_Reg ? mem_data : alu_result;
    end else if (w_hi_pending) begin
      r_wide    <= 1'b0;
      r_wr_addr <= c_hi_addr;
      r_wr_data <= r_hi_data;
    end
  end

endmodule

`default_nettype wire
